// File: rtl/uart_tx_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_sequencer_pkg: shared types for the UART TX sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    TXS_IDLE      = 3'd0,
    TXS_LOAD      = 3'd1,
    TXS_SEND      = 3'd2,
    TXS_WAIT_DONE = 3'd3,
    TXS_GAP       = 3'd4
  } tx_seq_state_t;

  // The gap counter must hold GAP_CYCLES itself; keep at least one bit when the gap is disabled.
  function automatic int gap_cnt_width(input int gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_sequencer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO with registered count/full/empty flags. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count_nxt;
  logic                  do_push;
  logic                  do_pop;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_COUNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sequencer.sv
// ----------------------------------------------------------------------------
// uart_tx_sequencer: FIFO-buffered autonomous sequencer for the UART TX. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    clr_overflow,
  input  logic                    tx_done,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_data_en,
  output logic                    tx_send,
  output logic                    busy,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  localparam int GW = gap_cnt_width(GAP_CYCLES);

  tx_seq_state_t          state;
  logic [GW-1:0]          gap_cnt;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   pop;

  // The only pop point is the IDLE->LOAD transition.
  assign pop = (state == TXS_IDLE) && !fifo_empty;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TXS_IDLE;
      gap_cnt    <= '0;
      tx_data    <= '0;
      tx_data_en <= 1'b0;
      tx_send    <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tx_data_en <= 1'b0;
      tx_send    <= 1'b0;

      if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      // Strobes and busy are set on the edge entering a state so they align with it.
      case (state)
        TXS_IDLE: begin
          if (!fifo_empty) begin
            state      <= TXS_LOAD;
            tx_data    <= fifo_rd_data;
            tx_data_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        TXS_LOAD: begin
          state   <= TXS_SEND;
          tx_send <= 1'b1;
        end
        TXS_SEND: begin
          state <= TXS_WAIT_DONE;
        end
        TXS_WAIT_DONE: begin
          if (tx_done) begin
            if (GAP_CYCLES == 0) begin
              state <= TXS_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= TXS_GAP;
              gap_cnt <= GW'(GAP_CYCLES);
            end
          end
        end
        TXS_GAP: begin
          if (gap_cnt <= GW'(1)) begin
            state   <= TXS_IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= TXS_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sequencer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sequencer: randomized bench with a timestamp-based reference model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_overflow = 1'b0;
  logic          tx_done;
  logic [DW-1:0] tx_data;
  logic          tx_data_en;
  logic          tx_send;
  logic          busy;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  uart_tx_sequencer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .tx_done      (tx_done),
    .tx_data      (tx_data),
    .tx_data_en   (tx_data_en),
    .tx_send      (tx_send),
    .busy         (busy),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a byte queue plus the cycle stamps of the current frame.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data  = '0;
  bit            m_ov    = 1'b0;
  bit            m_frame = 1'b0;
  int            m_load  = -100;
  int            m_done  = -1;
  int            m_free  = 0;
  int            mcyc    = 0;

  task automatic model_reset();
    mq.delete();
    m_data  = '0;
    m_ov    = 1'b0;
    m_frame = 1'b0;
    m_load  = -100;
    m_done  = -1;
  endtask

  task automatic model_step();
    bit was_idle;
    bit was_full;
    mcyc++;
    was_idle = !m_frame;
    was_full = (mq.size() == DEPTH);
    if (wr_en && was_full) m_ov = 1'b1;
    else if (clr_overflow) m_ov = 1'b0;
    if (was_idle && mq.size() != 0) begin
      m_data  = mq.pop_front();
      m_frame = 1'b1;
      m_load  = mcyc;
      m_done  = -1;
    end else if (m_frame) begin
      // A done is honoured only from the first cycle after the send cycle.
      if (m_done < 0 && tx_done && (mcyc - 1) >= m_load + 2) begin
        m_done = mcyc - 1;
        m_free = m_done + GAP + 1;
      end
      if (m_done >= 0 && mcyc >= m_free) m_frame = 1'b0;
    end
    if (wr_en && !was_full) mq.push_back(wr_data);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // UART responder: tx_done a programmable number of cycles after tx_send (0 = stalled).
  int tb_cyc       = 0;
  int done_delay   = 5;
  int done_target  = -1;
  bit spur_req     = 1'b0;
  bit spur_on_send = 1'b0;

  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      tb_cyc++;
      #2;
      tx_done = 1'b0;
      if (rst) done_target = -1;
      if (spur_req) begin
        tx_done  = 1'b1;
        spur_req = 1'b0;
      end
      if (tx_send === 1'b1) begin
        if (done_delay > 0) done_target = tb_cyc + done_delay;
        if (spur_on_send) begin
          tx_done      = 1'b1;
          spur_on_send = 1'b0;
        end
      end
      if (tb_cyc == done_target) begin
        tx_done     = 1'b1;
        done_target = -1;
      end
    end
  end

  logic [DW-1:0] sent_q[$];
  int            en_cyc[$];
  int            done_cyc[$];
  int            send_cnt = 0;

  initial begin
    logic [17:0] act_v;
    logic [17:0] exp_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_v = {m_data, (m_frame && mcyc == m_load), (m_frame && mcyc == m_load + 1), m_frame,
               (mq.size() == 0), (mq.size() == DEPTH), CW'(mq.size()), m_ov};
      act_v = {tx_data, tx_data_en, tx_send, busy, fifo_empty, fifo_full, fifo_count, overflow};
      chk("cycle_model", 32'(act_v), 32'(exp_v));
      if (tx_data_en === 1'b1) begin
        sent_q.push_back(tx_data);
        en_cyc.push_back(tb_cyc);
      end
      if (tx_send === 1'b1) send_cnt++;
      if (tx_done === 1'b1) done_cyc.push_back(tb_cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (!(fifo_empty === 1'b1 && busy === 1'b0) && n < max) begin
      tick(1);
      n++;
    end
    chk(name, 32'(n < max), 32'd1);
  endtask

  initial begin
    int nxt;
    int bad;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", {tx_data, tx_data_en, tx_send, busy, fifo_empty, fifo_full, fifo_count, overflow},
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});

    // Spurious done while idle.
    spur_req = 1'b1;
    tick(1);
    chk("spur_idle_busy", busy, 0);
    tick(1);
    chk("spur_idle_no_pop", {busy, fifo_empty, tx_data_en}, 3'b010);

    // Single byte with a spurious done during SEND.
    done_delay   = 5;
    spur_on_send = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick(1); wr_en = 1'b0;
    chk("a5_no_load_n1", tx_data_en, 0);
    tick(1);
    chk("a5_load_n2", {tx_data_en, tx_send, tx_data}, {1'b1, 1'b0, 8'hA5});
    tick(1);
    chk("a5_send_n3", {tx_data_en, tx_send, busy}, 3'b011);
    tick(1);
    chk("a5_send_one_cycle", {tx_send, busy}, 2'b01);
    tick(6);
    chk("a5_busy_in_gap", busy, 1);
    tick(1);
    chk("a5_idle_after_gap", {busy, tx_data}, {1'b0, 8'hA5});

    // Burst of three with slow UART.
    sent_q.delete(); en_cyc.delete(); done_cyc.delete();
    done_delay = 100;
    push(8'h01); push(8'h02); push(8'h03);
    wait_idle(600, "burst_drain");
    chk("burst_count", sent_q.size(), 3);
    chk("burst_b0", sent_q[0], 8'h01);
    chk("burst_b1", sent_q[1], 8'h02);
    chk("burst_b2", sent_q[2], 8'h03);
    chk("burst_gap1", en_cyc[1] - done_cyc[0], GAP + 2);
    chk("burst_gap2", en_cyc[2] - done_cyc[1], GAP + 2);
    chk("burst_empty", fifo_empty, 1);

    // Fill and overflow with the UART stalled.
    sent_q.delete();
    done_delay = 0;
    push(8'h30);
    tick(4);
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      tick(1);
    end
    wr_data = 8'hEE;
    tick(1); wr_en = 1'b0;
    chk("full_flags", {fifo_full, fifo_count, overflow}, {1'b1, 4'd8, 1'b1});
    clr_overflow = 1'b1;
    tick(1); clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wr_en = 1'b1; wr_data = 8'h77; clr_overflow = 1'b1;
    tick(1); wr_en = 1'b0; clr_overflow = 1'b0;
    chk("ovf_set_wins", {overflow, fifo_count}, {1'b1, 4'd8});
    clr_overflow = 1'b1;
    tick(1); clr_overflow = 1'b0;
    done_delay = 3;
    spur_req   = 1'b1;
    wait_idle(300, "ovf_drain");
    chk("ovf_sent_count", sent_q.size(), 9);
    chk("ovf_last_byte", sent_q[8], 8'h38);
    bad = 0;
    foreach (sent_q[k]) if (sent_q[k] == 8'hEE || sent_q[k] == 8'h77) bad++;
    chk("ovf_dropped_never_sent", bad, 0);

    // Asynchronous reset mid-WAIT_DONE with three bytes queued.
    done_delay = 0;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    tick(6);
    chk("rst_pre_queued", {busy, fifo_count}, {1'b1, 4'd3});
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {tx_data, tx_data_en, tx_send, busy, fifo_empty, fifo_full, fifo_count, overflow},
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
    @(posedge clk); #1 rst = 1'b0;
    sent_q.delete();
    send_cnt = 0;
    tick(30);
    chk("post_reset_no_send", send_cnt, 0);

    // Stream of 20 bytes across pointer wrap with overlapping push/pop.
    nxt = 0;
    while (nxt < 20) begin
      done_delay = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1 && fifo_count < CW'(DEPTH)) begin
        wr_en = 1'b1; wr_data = 8'(8'h10 + nxt); nxt++;
      end else begin
        wr_en = 1'b0;
      end
      tick(1);
    end
    wr_en = 1'b0;
    wait_idle(1000, "wrap_drain");
    chk("wrap_count", sent_q.size(), 20);
    for (int k = 0; k < 20; k++) chk("wrap_order", sent_q[k], 8'(8'h10 + k));

    // Free-running random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 400; c++) begin
      wr_en        = ($urandom_range(0, 2) == 0);
      wr_data      = 8'($urandom);
      clr_overflow = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) spur_req = 1'b1;
      done_delay   = $urandom_range(1, 8);
      tick(1);
    end
    wr_en = 1'b0;
    clr_overflow = 1'b0;
    wait_idle(1000, "random_drain");

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Buffers bytes the core writes to the UART TX data address in a small FIFO.
- Sequences the UART transmitter autonomously: load data register, pulse send, wait for frame completion, enforce an inter-frame gap, repeat until the FIFO is empty.
- Sits between the memory-map controller's TX write decode and the full-duplex UART's TX inputs.
- Removes software polling of the TX STOP state per byte.

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- DATA_WIDTH, 8: byte width of the UART frame payload.
- GAP_CYCLES, 2: idle clk cycles inserted after each tx_done before the next load; 0 is legal.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  push strobe from memory-map controller (one cycle per store).
- wr_data  input  DATA_WIDTH  byte to enqueue.
- clr_overflow  input  1  clears sticky overflow flag.
- tx_done  input  1  UART transmitter single-cycle pulse at end of stop bit.
- tx_data  output  DATA_WIDTH  byte presented to UART TX data register.
- tx_data_en  output  1  one-cycle load strobe for UART TX data register.
- tx_send  output  1  one-cycle start-of-frame strobe to UART transmitter.
- busy  output  1  high whenever FSM is not IDLE.
- fifo_empty  output  1  FIFO holds 0 entries.
- fifo_full  output  1  FIFO holds DEPTH entries.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a push was attempted while full.

Behaviour:
- Reset, asynchronous: FSM=IDLE, read and write pointers=0, count=0, gap counter=0, overflow=0.
- Output reset values: tx_data=0, tx_data_en=0, tx_send=0, busy=0, fifo_empty=1, fifo_full=0.
- All outputs are registered.
- Reset mid-frame aborts sequencing immediately and discards FIFO contents. The UART's own reset handles the line.
- Push: on the clk edge where wr_en=1 and count<DEPTH, write mem[wptr]=wr_data, advance wptr (wraps modulo DEPTH) and increment count.
- Push when full (count==DEPTH), even if a pop happens the same cycle: byte dropped, overflow set to 1.
- Pop: occurs only in the IDLE→LOAD transition. Captures mem[rptr] into tx_data and advances rptr (wraps).
- Simultaneous push and pop with count<DEPTH: count unchanged and both pointers advance.
- overflow: clr_overflow=1 clears it. If clr_overflow and a set condition occur in the same cycle, set wins.
- FSM states: IDLE, LOAD, SEND, WAIT_DONE, GAP.
- IDLE: if count≠0, go to LOAD (pop). Otherwise stay.
- LOAD: tx_data_en=1 for this single cycle; tx_data is stable. Next state SEND.
- SEND: tx_send=1 for this single cycle. Next state WAIT_DONE.
- WAIT_DONE: hold tx_data. On tx_done=1, load gap counter with GAP_CYCLES and go to GAP, or go directly to IDLE if GAP_CYCLES==0. tx_done pulses in any other state are ignored.
- GAP: decrement the counter each cycle; when it reaches 0, go to IDLE.
- Latency: a wr_en edge at cycle N into an empty, idle block gives tx_data_en high in cycle N+2 and tx_send high in cycle N+3.
- Back-to-back frames: next tx_data_en occurs GAP_CYCLES+2 cycles after the tx_done cycle.
- tx_data holds the last popped byte until the next pop.
- No timeout: WAIT_DONE waits indefinitely. The UART guarantees tx_done.

Decomposition:
- Add tx_seq_state_t enum (IDLE, LOAD, SEND, WAIT_DONE, GAP) to UART_pkg alongside rx_state_t/tx_state_t.
- Export the state as an optional debug output later.
- One natural sub-module: sync_fifo (parameterised DEPTH/DATA_WIDTH, push/pop/count/full/empty). It is reusable for a future RX buffer.
- FSM and gap counter stay in the top.

Test Plan:
- Reset: assert rst mid-WAIT_DONE with 3 bytes queued → all outputs return to reset values asynchronously; fifo_count=0; no tx_send after release.
- Single byte: write 8'hA5 at cycle N → tx_data_en=1 at N+2 with tx_data=8'hA5, tx_send=1 at N+3 only; busy=1 until GAP ends; each strobe is exactly one cycle wide.
- Burst with GAP_CYCLES=2: write 8'h01,8'h02,8'h03 back-to-back; model tx_done 100 cycles after each tx_send → three frames in order; each next tx_data_en exactly 4 cycles after tx_done; fifo_empty=1 at end.
- Full and overflow, DEPTH=8, UART stalled in WAIT_DONE: nine pushes → fifo_full=1, count=8, overflow=1, ninth byte never transmitted. clr_overflow → overflow=0. Set and clear in the same cycle → overflow stays 1.
- Wrap-around and simultaneous push/pop: stream 20 bytes 8'h10..8'h23, timed so a push coincides with the IDLE→LOAD pop → transmitted order matches write order; count is correct across pointer wrap.
- Spurious tx_done pulsed in IDLE and SEND → ignored; no state change and no extra pop.
